// File: rtl/debounce_pkg.sv
// Shared definitions for the multi-channel push-button debouncer.
// Provides the constant clog2 helper, input polarity codes, default timing
// constants and the per-channel event encoding used by debounce_channel.
package debounce_pkg;

  // Raw input polarity: ACT_LOW means a pressed button pulls the line low.
  localparam int ACT_LOW  = 1;
  localparam int ACT_HIGH = 0;

  // Default timing, matching a 50 MHz board with 1 kHz sampling.
  localparam int DEF_CHANNELS           = 4;
  localparam int DEF_CLK_HZ             = 50_000_000;
  localparam int DEF_TICK_HZ            = 1000;
  localparam int DEF_DEBOUNCE_TICKS     = 40;
  localparam int DEF_REPEAT_DELAY_TICKS = 500;
  localparam int DEF_REPEAT_RATE_TICKS  = 100;

  // Outcome of one sample tick for one channel.
  typedef enum logic [1:0] {
    EV_NONE    = 2'd0,
    EV_PRESS   = 2'd1,
    EV_RELEASE = 2'd2
  } btn_ev_t;

  // Number of bits needed to hold values 0..value-1 (minimum 1 for value<=2).
  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) begin
      r = r + 1;
    end
    if (r == 0) begin
      r = 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debouncer lane: 2-FF synchroniser, stable-sample counter, clean level
// and one-clk press/release strobes, evaluated only on prescaler ticks.
// Latency: 2 clk sync + DEBOUNCE_TICKS ticks; no backpressure (strobes are
// fire-and-forget).
// Optional: `define DEBOUNCE_AUTOREPEAT_EN adds the hold-to-repeat strobe.
//
// Ports:
//   clk, rst       clock and asynchronous active-high reset
//   tick           shared sample strobe from the top-level prescaler
//   btn_raw        asynchronous raw button level
//   btn_state      debounced level, 1 = pressed
//   btn_press      one-clk strobe when a press is accepted
//   btn_release    one-clk strobe when a release is accepted
//   btn_repeat     (autorepeat build only) one-clk repeat strobe while held
module debounce_channel
  import debounce_pkg::*;
#(
  parameter int ACTIVE_LOW     = ACT_LOW,
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS
`ifdef DEBOUNCE_AUTOREPEAT_EN
  , parameter int REPEAT_DELAY_TICKS = DEF_REPEAT_DELAY_TICKS
  , parameter int REPEAT_RATE_TICKS  = DEF_REPEAT_RATE_TICKS
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn_raw,
  output logic btn_state,
  output logic btn_press,
  output logic btn_release
`ifdef DEBOUNCE_AUTOREPEAT_EN
  , output logic btn_repeat
`endif
);

  localparam int              CNT_W    = clog2(DEBOUNCE_TICKS + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_TICKS - 1);
  // Raw level of a released button; the synchroniser resets to it so the
  // lane never sees a phantom press coming out of reset.
  localparam logic            IDLE_LVL = (ACTIVE_LOW != 0);

  logic [1:0]       sync_q;
  logic             act;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_nxt;
  logic             state_nxt;
  btn_ev_t          ev;

  // Two-flop synchroniser; sync_q[1] is the metastability-safe sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {2{IDLE_LVL}};
    end else begin
      sync_q <= {sync_q[0], btn_raw};
    end
  end

  // Normalise polarity: act = 1 means "pressed".
  assign act = sync_q[1] ^ IDLE_LVL;

  // Stable counter: counts consecutive ticks whose sample disagrees with the
  // current debounced level. Any agreeing sample restarts the count, so a
  // bounce shorter than DEBOUNCE_TICKS ticks never reaches the toggle point.
  // The counter is cleared on the toggle tick and therefore never wraps.
  always_comb begin
    cnt_nxt   = cnt_q;
    state_nxt = btn_state;
    ev        = EV_NONE;
    if (tick) begin
      if (act == btn_state) begin
        cnt_nxt = '0;
      end else if (cnt_q == CNT_LAST) begin
        cnt_nxt   = '0;
        state_nxt = ~btn_state;
        ev        = btn_state ? EV_RELEASE : EV_PRESS;
      end else begin
        cnt_nxt = cnt_q + 1'b1;
      end
    end
  end

  // Level and strobes are registered together, so a strobe lines up with the
  // first cycle of the new level and lasts exactly one clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q       <= '0;
      btn_state   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
    end else begin
      cnt_q       <= cnt_nxt;
      btn_state   <= state_nxt;
      btn_press   <= (ev == EV_PRESS);
      btn_release <= (ev == EV_RELEASE);
    end
  end

`ifdef DEBOUNCE_AUTOREPEAT_EN
  // Hold-to-repeat: after a press, count ticks while the level stays high.
  // The first repeat lands REPEAT_DELAY_TICKS ticks after the press tick,
  // then every REPEAT_RATE_TICKS. rpt_phase_q selects which interval the
  // counter is currently timing.
  localparam int RPT_MAX = (REPEAT_DELAY_TICKS > REPEAT_RATE_TICKS) ?
                           REPEAT_DELAY_TICKS : REPEAT_RATE_TICKS;
  localparam int               RPT_W     = clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY = RPT_W'(REPEAT_DELAY_TICKS);
  localparam logic [RPT_W-1:0] RPT_RATE  = RPT_W'(REPEAT_RATE_TICKS);

  logic [RPT_W-1:0] rpt_cnt_q;
  logic [RPT_W-1:0] rpt_cnt_nxt;
  logic [RPT_W-1:0] rpt_inc;
  logic             rpt_phase_q;
  logic             rpt_phase_nxt;
  logic             rpt_hit;

  always_comb begin
    rpt_cnt_nxt   = rpt_cnt_q;
    rpt_phase_nxt = rpt_phase_q;
    rpt_hit       = 1'b0;
    rpt_inc       = rpt_cnt_q + 1'b1;
    if (tick) begin
      // Released, or the level toggles on this tick: restart from scratch.
      // This also keeps a repeat from coinciding with btn_press.
      if (!btn_state || (ev != EV_NONE)) begin
        rpt_cnt_nxt   = '0;
        rpt_phase_nxt = 1'b0;
      end else if (rpt_inc == (rpt_phase_q ? RPT_RATE : RPT_DELAY)) begin
        rpt_cnt_nxt   = '0;
        rpt_phase_nxt = 1'b1;
        rpt_hit       = 1'b1;
      end else begin
        rpt_cnt_nxt = rpt_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rpt_cnt_q   <= '0;
      rpt_phase_q <= 1'b0;
      btn_repeat  <= 1'b0;
    end else begin
      rpt_cnt_q   <= rpt_cnt_nxt;
      rpt_phase_q <= rpt_phase_nxt;
      btn_repeat  <= rpt_hit;
    end
  end
`endif

endmodule

// File: rtl/debounce_multi.sv
// N-channel push-button debouncer feeding UART control (send trigger, baud
// select). Latency: 2 clk + DEBOUNCE_TICKS ticks (+ up to TICK_DIV clk phase)
// from a clean edge to btn_state; no backpressure, strobes are one clk wide.
// Optional: `define DEBOUNCE_AUTOREPEAT_EN adds REPEAT_* parameters and the
// btn_repeat output; without it no repeat port or logic exists.
//
// Ports:
//   clk          system clock
//   rst          asynchronous active-high reset
//   btn_raw      CHANNELS glitchy asynchronous button inputs
//   btn_state    CHANNELS debounced levels, 1 = pressed
//   btn_press    CHANNELS one-clk accepted-press strobes
//   btn_release  CHANNELS one-clk accepted-release strobes
//   btn_repeat   CHANNELS one-clk hold-repeat strobes (autorepeat build only)
//   tick         one-clk sample strobe, exported for reuse elsewhere
//
// Parameter ranges: CHANNELS 1..32, CLK_HZ/TICK_HZ >= 2, DEBOUNCE_TICKS 1..255.
module debounce_multi
  import debounce_pkg::*;
#(
  parameter int CHANNELS       = DEF_CHANNELS,
  parameter int CLK_HZ         = DEF_CLK_HZ,
  parameter int TICK_HZ        = DEF_TICK_HZ,
  parameter int DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int ACTIVE_LOW     = ACT_LOW
`ifdef DEBOUNCE_AUTOREPEAT_EN
  , parameter int REPEAT_DELAY_TICKS = DEF_REPEAT_DELAY_TICKS
  , parameter int REPEAT_RATE_TICKS  = DEF_REPEAT_RATE_TICKS
`endif
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] btn_raw,
  output logic [CHANNELS-1:0] btn_state,
  output logic [CHANNELS-1:0] btn_press,
  output logic [CHANNELS-1:0] btn_release,
  output logic                tick
`ifdef DEBOUNCE_AUTOREPEAT_EN
  , output logic [CHANNELS-1:0] btn_repeat
`endif
);

  localparam int                 TICK_DIV   = CLK_HZ / TICK_HZ;
  localparam int                 PRESC_W    = clog2(TICK_DIV);
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);

  logic [PRESC_W-1:0] presc_q;

  // Shared prescaler: runs 0..TICK_DIV-1 and wraps. tick is decoded from the
  // terminal count so it is high for exactly that one cycle, and low in reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else if (presc_q == PRESC_LAST) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_q + 1'b1;
    end
  end

  assign tick = (presc_q == PRESC_LAST);

  // Channels are fully independent; accepts on several lanes in the same
  // tick strobe together.
  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    debounce_channel #(
      .ACTIVE_LOW         (ACTIVE_LOW),
      .DEBOUNCE_TICKS     (DEBOUNCE_TICKS)
`ifdef DEBOUNCE_AUTOREPEAT_EN
      , .REPEAT_DELAY_TICKS (REPEAT_DELAY_TICKS)
      , .REPEAT_RATE_TICKS  (REPEAT_RATE_TICKS)
`endif
    ) u_ch (
      .clk         (clk),
      .rst         (rst),
      .tick        (tick),
      .btn_raw     (btn_raw[g]),
      .btn_state   (btn_state[g]),
      .btn_press   (btn_press[g]),
      .btn_release (btn_release[g])
`ifdef DEBOUNCE_AUTOREPEAT_EN
      , .btn_repeat  (btn_repeat[g])
`endif
    );
  end

endmodule

// File: doc/debounce_multi.md
Name: debounce_multi

Overview:
- Parametrised N-channel push-button debouncer; successor to the single-button debouncer.
- Sits between raw board inputs (buttons/switches) and UART control logic (send trigger, baud select).
- Per channel: synchronises the input, applies a symmetric press/release debounce, and outputs a clean level plus one-cycle press/release strobes.
- Runs from a single clock enable tick; no derived clocks.

Parameters:
- CHANNELS, 4, number of independent inputs (1..32).
- CLK_HZ, 50000000, system clock frequency.
- TICK_HZ, 1000, debounce sample rate; TICK_DIV = CLK_HZ/TICK_HZ, must be >= 2.
- DEBOUNCE_TICKS, 40, consecutive stable ticks required to accept a change (1..255).
- ACTIVE_LOW, 1, 1: raw input low means pressed; 0: high means pressed.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- btn_raw  in  CHANNELS  glitchy asynchronous button inputs.
- btn_state  out  CHANNELS  debounced level, 1 = pressed.
- btn_press  out  CHANNELS  one-clk strobe on accepted press.
- btn_release  out  CHANNELS  one-clk strobe on accepted release.
- tick  out  1  one-clk sample strobe, exported for reuse.

Behaviour:
- Interface: one clock `clk`; reset `rst` is asynchronous and active-high.
- Reset values:
  - all outputs 0; prescaler 0; all channel counters 0.
  - synchroniser flops load the inactive level (so no phantom press after reset).
- Prescaler:
  - counter 0..TICK_DIV-1; `tick`=1 for the one cycle when counter == TICK_DIV-1, then wraps to 0.
  - Width is clog2(TICK_DIV).
- Synchroniser:
  - 2-FF per channel.
  - `act` = synced bit XOR ACTIVE_LOW.
- Per channel, evaluated only on cycles with tick=1:
  - act == btn_state: counter cleared to 0.
  - act != btn_state and counter < DEBOUNCE_TICKS-1: counter increments.
  - act != btn_state and counter == DEBOUNCE_TICKS-1: btn_state toggles, counter clears, and btn_press (new state 1) or btn_release (new state 0) asserts.
- Strobes:
  - registered together with btn_state; high exactly one clk.
  - btn_press and btn_release are never high together on the same channel.
- Latency: 2 clk synchroniser + DEBOUNCE_TICKS ticks (+ up to TICK_DIV clk phase) from a clean input edge to btn_state change.
- Glitch rejection: any tick sampling act == btn_state restarts the count. A bounce shorter than DEBOUNCE_TICKS ticks never changes the output.
- Counter width is clog2(DEBOUNCE_TICKS+1); the counter never exceeds DEBOUNCE_TICKS-1 (no wrap).
- Channels are fully independent; simultaneous accepts on several channels all strobe in the same cycle.
- rst asserted mid-count: immediate clear. After release, a held button needs a full DEBOUNCE_TICKS to be accepted.
- Cycles with tick=0: channel state and counters hold.

Optional Feature:
- Macro: DEBOUNCE_AUTOREPEAT_EN.
- Defined:
  - Adds parameters REPEAT_DELAY_TICKS (default 500) and REPEAT_RATE_TICKS (default 100), plus output btn_repeat[CHANNELS].
  - While btn_state=1, a per-channel hold counter counts ticks.
  - btn_repeat strobes one clk at REPEAT_DELAY_TICKS after the press, then every REPEAT_RATE_TICKS.
  - Counter clears on release or rst. No repeat strobe in the same cycle as btn_press.
- Undefined: no port, no logic.

Decomposition:
- Package debounce_pkg:
  - clog2 function.
  - polarity constants ACT_LOW=1, ACT_HIGH=0.
  - default timing constants.
- Sub-module debounce_channel: synchroniser, stable counter, state and strobes (plus the optional repeat logic), instantiated CHANNELS times via generate.
- Prescaler stays in the top level; it is shared.

Test Plan:
(Sim parameters: CLK_HZ=1000, TICK_HZ=100 -> TICK_DIV=10; DEBOUNCE_TICKS=4; CHANNELS=2; ACTIVE_LOW=1.)
- Reset: hold rst, drive btn_raw=2'b00 -> all outputs 0. After release, no press strobe until a full 4 ticks elapse.
- Clean press: ch0 low and held -> btn_state[0] rises on the 4th tick after sync, with btn_press[0] high exactly 1 clk. Ch1 is unaffected.
- Bounce: ch0 toggles low for 3 ticks, high for 1, repeated 5 times -> btn_state stays 0 and no strobes.
- Release: after an accepted press, drive ch0 high -> btn_release[0] one clk strobe 4 ticks later, btn_state[0] = 0.
- Simultaneous: both channels pressed on the same clk -> btn_press=2'b11 in the same cycle. rst mid-count (tick 2) -> counters clear and acceptance restarts.
- Autorepeat (macro defined, DELAY=6, RATE=3): hold ch0 -> repeat strobes at 6, 9, 12 ticks after press; release stops them.
